// File: rtl/fetch_pkg.sv
// Shared types and defaults for the parametrised instruction-fetch stage.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 9;
    localparam int INSTR_W_DEF = 33;
    localparam int CNT_W_DEF   = 16;

    // Bubble encoding presented to ID when no real instruction is held
    localparam logic [INSTR_W_DEF-1:0] NOP_DEF = '0;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    // IF/ID register layout at the default widths; the top builds the same
    // layout from its own parameters.
    typedef struct packed {
        logic [INSTR_W_DEF-1:0] instr;
        logic [ADDR_W_DEF-1:0]  pc;
        logic [ADDR_W_DEF-1:0]  pc_plus;
        logic                   valid;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_param_if.sv
// Instruction-memory read port: fetch stage is master, memory is slave.
interface fetch_stage_param_if #(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 33
);
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_pc_sel.sv
// Next-PC priority mux: return beats branch beats stall beats sequential.
module fetch_pc_sel #(
    parameter int ADDR_W  = 9,
    parameter int PC_STEP = 1
) (
    input  logic [ADDR_W-1:0] pc_f,
    input  logic              stall_eff,
    input  logic              pc_src_e,
    input  logic [ADDR_W-1:0] pc_target_e,
    input  logic              pc_return_sig_e,
    input  logic [ADDR_W-1:0] pc_return_e,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [ADDR_W-1:0] pc_next
);

    // Sequential increment wraps naturally at the address width
    assign pc_plus = pc_f + ADDR_W'(PC_STEP);

    // Priority select of the next fetch address
    always_comb begin
        pc_next = pc_plus;
        if (pc_return_sig_e)
            pc_next = pc_return_e;
        else if (pc_src_e)
            pc_next = pc_target_e;
        else if (stall_eff)
            pc_next = pc_f;
    end

endmodule

// File: rtl/fetch_stage_param.sv
// IF stage with IF/ID pipeline register, boot bubble and fetch/stall counters.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  BOOT  | first cycle after reset; imem output not yet valid, ID bubbled
//  RUN   | normal fetch; left only through rst
module fetch_stage_param
    import fetch_pkg::*;
#(
    parameter int                 ADDR_W    = ADDR_W_DEF,
    parameter int                 INSTR_W   = INSTR_W_DEF,
    parameter int                 PC_STEP   = 1,
    parameter int                 RESET_PC  = 0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall_f,
    input  logic                stall_d,
    input  logic                flush_d,
    input  logic                pc_src_e,
    input  logic [ADDR_W-1:0]   pc_target_e,
    input  logic                pc_return_sig_e,
    input  logic [ADDR_W-1:0]   pc_return_e,
    fetch_stage_param_if.master imem,
    output logic [INSTR_W-1:0]  instr_d,
    output logic [ADDR_W-1:0]   pc_d,
    output logic [ADDR_W-1:0]   pc_plus_d,
    output logic                valid_d,
    output logic [CNT_W-1:0]    fetch_cnt,
    output logic [CNT_W-1:0]    stall_cnt
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus;
        logic               valid;
    } ifid_reg_t;

    localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic [ADDR_W-1:0] pc_f;
    logic [ADDR_W-1:0] pc_plus_f;
    logic [ADDR_W-1:0] pc_sel_next;
    logic [ADDR_W-1:0] pc_fetch;
    logic              imem_en_c;
    logic              stall_eff;
    logic              redirect;
    logic              run;
    logic              load_valid;
    ifid_reg_t         ifid_q;

    assign stall_eff = stall_f | stall_d;
    assign redirect  = pc_return_sig_e | pc_src_e;
    assign run       = (state_q == RUN);
    // A real instruction enters ID only when nothing bubbles or holds it
    assign load_valid = run & ~redirect & ~flush_d & ~stall_d & ~stall_f;

    fetch_pc_sel #(
        .ADDR_W  (ADDR_W),
        .PC_STEP (PC_STEP)
    ) u_pc_sel (
        .pc_f            (pc_f),
        .stall_eff       (stall_eff),
        .pc_src_e        (pc_src_e),
        .pc_target_e     (pc_target_e),
        .pc_return_sig_e (pc_return_sig_e),
        .pc_return_e     (pc_return_e),
        .pc_plus         (pc_plus_f),
        .pc_next         (pc_sel_next)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= BOOT;
        else
            state_q <= state_d;
    end

    // Next state and fetch-address / enable outputs; BOOT pins fetch at RESET_PC
    always_comb begin
        state_d   = state_q;
        pc_fetch  = RESET_ADDR;
        imem_en_c = 1'b1;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                pc_fetch  = pc_sel_next;
                imem_en_c = ~stall_eff | redirect;
            end
        endcase
    end

    assign imem.imem_en   = imem_en_c;
    assign imem.imem_addr = pc_fetch;

    // Fetch PC tracks the address presented to imem this cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_f <= RESET_ADDR;
        else
            pc_f <= pc_fetch;
    end

    // IF/ID register: bubble on boot/redirect/flush/stall_f, hold on stall_d
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q.instr   <= NOP_INSTR;
            ifid_q.pc      <= '0;
            ifid_q.pc_plus <= '0;
            ifid_q.valid   <= 1'b0;
        end else if (!run || redirect || flush_d) begin
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
        end else if (stall_d) begin
            ifid_q <= ifid_q;
        end else if (stall_f) begin
            ifid_q.instr <= NOP_INSTR;
            ifid_q.valid <= 1'b0;
        end else begin
            ifid_q.instr   <= imem.imem_rdata;
            ifid_q.pc      <= pc_f;
            ifid_q.pc_plus <= pc_plus_f;
            ifid_q.valid   <= 1'b1;
        end
    end

    assign instr_d   = ifid_q.instr;
    assign pc_d      = ifid_q.pc;
    assign pc_plus_d = ifid_q.pc_plus;
    assign valid_d   = ifid_q.valid;

    // Saturating count of real instructions delivered to ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_cnt <= '0;
        else if (load_valid && fetch_cnt != {CNT_W{1'b1}})
            fetch_cnt <= fetch_cnt + 1'b1;
    end

    // Saturating count of RUN cycles spent stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (run && stall_eff && stall_cnt != {CNT_W{1'b1}})
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule
